// File: rtl/hub75_pkg.sv
// Shared types and helpers for the HUB75 BCM scanner.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package hub75_pkg;

  // Scanner phase: fetch/shift a bit plane, latch it, then light it.
  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH,
    DISPLAY
  } state_t;

  // Widest colour depth the pixel helper accepts; pixels are zero-extended to this.
  localparam int MAX_DEPTH = 16;
  localparam int PX_W      = 3 * MAX_DEPTH;

  // Bits for a counter indexed by $clog2(n), never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Pick bit 'plane' of each channel of a {R,G,B} pixel whose channels are
  // 'depth' bits wide. Returns {R,G,B}.
  function automatic logic [2:0] plane_bits(input logic [PX_W-1:0] px,
                                            input int depth,
                                            input int plane);
    logic r, g, b;
    r = |((px >> (2 * depth + plane)) & PX_W'(1));
    g = |((px >> (depth + plane)) & PX_W'(1));
    b = |((px >> plane) & PX_W'(1));
    return {r, g, b};
  endfunction

endpackage

// File: rtl/hub75_bcm_timer.sv
// Loadable down-counter timing the lit period of one bit plane.
// Latency: load takes effect next cycle; done is high while the count sits at 0,
//   so a value L loaded the cycle before yields exactly L cycles up to and including done.
// Backpressure: none; free-runs down to zero and holds there.
// Ports: clk, rst (sync, active-low), load/load_val (start a period), done.
module hub75_bcm_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val - W'(1);
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/hub75_bcm_scanner.sv
// HUB75 panel-chain scanner with binary-code-modulated colour depth.
// Latency: frame source read is 1 cycle; all panel outputs are registered.
// Backpressure: none; enable low parks the scanner in IDLE after the current row.
// Ports: clk, rst (sync, active-low), enable; col/row -> frame source, px1/px2 <- source;
//   sclk/lat/blank/disp_row/rgb1/rgb2 -> panel pins; frame_start marks row 0 / plane 0.
module hub75_bcm_scanner
  import hub75_pkg::*;
#(
  parameter int NUM_PANELS  = 4,
  parameter int PANEL_COLS  = 32,
  parameter int ROW_BITS    = 3,
  parameter int COLOR_DEPTH = 4,   // 1..MAX_DEPTH
  parameter int BASE_ON     = 8    // >= 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   enable,
  output logic [$clog2(NUM_PANELS*PANEL_COLS)-1:0] col,
  output logic [ROW_BITS-1:0]                    row,
  input  logic [3*COLOR_DEPTH-1:0]               px1,
  input  logic [3*COLOR_DEPTH-1:0]               px2,
  output logic                                   sclk,
  output logic                                   lat,
  output logic                                   blank,
  output logic [ROW_BITS-1:0]                    disp_row,
  output logic [2:0]                             rgb1,
  output logic [2:0]                             rgb2,
  output logic                                   frame_start
);

  localparam int NUM_COLS  = NUM_PANELS * PANEL_COLS;
  localparam int COL_W     = $clog2(NUM_COLS);
  localparam int SHIFT_LEN = 2 * NUM_COLS + 2;
  localparam int SHIFT_W   = cnt_width(SHIFT_LEN);
  localparam int MAX_ON    = BASE_ON << (COLOR_DEPTH - 1);
  localparam int DISP_W    = cnt_width(MAX_ON) + 1;
  localparam int PLANE_W   = cnt_width(COLOR_DEPTH);

  localparam logic [SHIFT_W-1:0] SHIFT_LAST = SHIFT_W'(SHIFT_LEN - 1);
  localparam logic [SHIFT_W-1:0] LAST_FETCH = SHIFT_W'(2 * NUM_COLS - 1);
  localparam logic [SHIFT_W-1:0] LAST_RISE  = SHIFT_W'(2 * NUM_COLS);
  localparam logic [SHIFT_W-1:0] FIRST_RISE = SHIFT_W'(2);
  localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(COLOR_DEPTH - 1);
  localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(NUM_COLS - 1);

  state_t               state, state_nxt;
  logic [PLANE_W-1:0]   plane, plane_nxt;
  logic [ROW_BITS-1:0]  row_nxt;
  logic [SHIFT_W-1:0]   shift_cnt;
  logic [DISP_W-1:0]    on_time;
  logic                 timer_done;
  logic                 shift_entry;
  logic [PX_W-1:0]      px1_ext, px2_ext;

  assign px1_ext = PX_W'(px1);
  assign px2_ext = PX_W'(px2);
  assign on_time = DISP_W'(BASE_ON) << plane;

  hub75_bcm_timer #(
    .W (DISP_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (state == LATCH),
    .load_val (on_time),
    .done     (timer_done)
  );

  // Next-state / scan-position logic. enable is only consulted in IDLE and
  // after the last plane of a row, so a row always gets its full colour depth
  // and a lit period is never cut short.
  always_comb begin
    state_nxt = state;
    plane_nxt = plane;
    row_nxt   = row;
    unique case (state)
      IDLE: begin
        if (enable) begin
          state_nxt = SHIFT;
          plane_nxt = '0;
          row_nxt   = '0;
        end
      end
      SHIFT: begin
        if (shift_cnt == SHIFT_LAST) state_nxt = LATCH;
      end
      LATCH: begin
        state_nxt = DISPLAY;
      end
      DISPLAY: begin
        if (timer_done) begin
          if (plane != PLANE_LAST) begin
            plane_nxt = plane + PLANE_W'(1);
            state_nxt = SHIFT;
          end else begin
            plane_nxt = '0;
            if (enable) begin
              row_nxt   = row + ROW_BITS'(1);
              state_nxt = SHIFT;
            end else begin
              // Stopping forgets the scan position: resuming begins a new frame.
              row_nxt   = '0;
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign shift_entry = (state != SHIFT) && (state_nxt == SHIFT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      plane <= '0;
    end else begin
      state <= state_nxt;
      plane <= plane_nxt;
    end
  end

  // Registered outputs. Control pins are derived from the next state so they
  // line up with the state they describe; blank drops only for DISPLAY.
  always_ff @(posedge clk) begin
    if (!rst) begin
      row         <= '0;
      col         <= '0;
      shift_cnt   <= '0;
      sclk        <= 1'b0;
      lat         <= 1'b0;
      blank       <= 1'b1;
      disp_row    <= '0;
      rgb1        <= '0;
      rgb2        <= '0;
      frame_start <= 1'b0;
    end else begin
      row         <= row_nxt;
      blank       <= (state_nxt != DISPLAY);
      lat         <= (state_nxt == LATCH);
      frame_start <= shift_entry && (row_nxt == '0) && (plane_nxt == '0);

      // The panel row select moves only while the panel is dark.
      if (state_nxt == LATCH) disp_row <= row_nxt;

      // Local shift timeline t counts from 0 at SHIFT entry.
      if ((state == SHIFT) && (state_nxt == SHIFT)) shift_cnt <= shift_cnt + SHIFT_W'(1);
      else                                          shift_cnt <= '0;

      // Column c is addressed for t=2c,2c+1 and parks on the last column.
      if (shift_entry) begin
        col <= '0;
      end else if ((state == SHIFT) && shift_cnt[0] && (col != COL_LAST)) begin
        col <= col + COL_W'(1);
      end

      // Pixel data arrives one cycle after its address: capture at the end of
      // t=2c+1 so the bit is on the pins for t=2c+2 and 2c+3.
      if ((state == SHIFT) && shift_cnt[0] && (shift_cnt <= LAST_FETCH)) begin
        rgb1 <= plane_bits(px1_ext, COLOR_DEPTH, int'(plane));
        rgb2 <= plane_bits(px2_ext, COLOR_DEPTH, int'(plane));
      end

      // Rising edge one cycle after the data changes: high at t=2c+3.
      sclk <= (state == SHIFT) && !shift_cnt[0] &&
              (shift_cnt >= FIRST_RISE) && (shift_cnt <= LAST_RISE);
    end
  end

endmodule

// File: tb/tb_hub75_bcm_scanner.sv
// Self-checking bench for hub75_bcm_scanner: a small configuration checked
// cycle by cycle against a phase-by-phase model of the scan, plus a deep-colour
// configuration used for on-time lengths and reset-while-lit.
module tb_hub75_bcm_scanner;

  localparam int N    = 4;   // columns (1 panel x 4)
  localparam int ROWS = 2;
  localparam int D    = 2;
  localparam int BO   = 3;
  localparam int DB   = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Small configuration
  logic       rst, enable;
  logic [1:0] col;
  logic [0:0] row, disp_row;
  logic [5:0] px1, px2;
  logic       sclk, lat, blank, frame_start;
  logic [2:0] rgb1, rgb2;

  // Deep-colour configuration
  logic        rst_b, en_b;
  logic [1:0]  col_b;
  logic [0:0]  row_b, disp_row_b;
  logic [23:0] px1_b, px2_b;
  logic        sclk_b, lat_b, blank_b, frame_start_b;
  logic [2:0]  rgb1_b, rgb2_b;

  hub75_bcm_scanner #(
    .NUM_PANELS(1), .PANEL_COLS(N), .ROW_BITS(1), .COLOR_DEPTH(D), .BASE_ON(BO)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .col(col), .row(row),
    .px1(px1), .px2(px2), .sclk(sclk), .lat(lat), .blank(blank),
    .disp_row(disp_row), .rgb1(rgb1), .rgb2(rgb2), .frame_start(frame_start)
  );

  hub75_bcm_scanner #(
    .NUM_PANELS(1), .PANEL_COLS(N), .ROW_BITS(1), .COLOR_DEPTH(DB), .BASE_ON(1)
  ) dut_b (
    .clk(clk), .rst(rst_b), .enable(en_b), .col(col_b), .row(row_b),
    .px1(px1_b), .px2(px2_b), .sclk(sclk_b), .lat(lat_b), .blank(blank_b),
    .disp_row(disp_row_b), .rgb1(rgb1_b), .rgb2(rgb2_b), .frame_start(frame_start_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [5:0] mem1 [ROWS][N];
  logic [5:0] mem2 [ROWS][N];
  int prev_row, prev_col;
  int model_disp_row;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the frame source answers the previous cycle's address.
  task automatic step();
    @(posedge clk);
    #1;
    px1 = mem1[1'(prev_row)][2'(prev_col)];
    px2 = mem2[1'(prev_row)][2'(prev_col)];
    prev_row = int'(row);
    prev_col = int'(col);
  endtask

  // {R,G,B} bit p of a pixel holding three 2-bit channels, R in the top bits.
  function automatic logic [2:0] model_bits(input logic [5:0] px, input int p);
    logic [1:0] r, g, b;
    r = px[5:4] >> p;
    g = px[3:2] >> p;
    b = px[1:0] >> p;
    return {r[0], g[0], b[0]};
  endfunction

  task automatic check_reset_a(input string tag);
    chk({tag, "_blank"}, 32'(blank), 1);
    chk({tag, "_sclk"}, 32'(sclk), 0);
    chk({tag, "_lat"}, 32'(lat), 0);
    chk({tag, "_disp_row"}, 32'(disp_row), 0);
    chk({tag, "_rgb1"}, 32'(rgb1), 0);
    chk({tag, "_rgb2"}, 32'(rgb2), 0);
    chk({tag, "_col"}, 32'(col), 0);
    chk({tag, "_row"}, 32'(row), 0);
    chk({tag, "_frame_start"}, 32'(frame_start), 0);
  endtask

  task automatic check_reset_b(input string tag);
    chk({tag, "_blank"}, 32'(blank_b), 1);
    chk({tag, "_sclk"}, 32'(sclk_b), 0);
    chk({tag, "_lat"}, 32'(lat_b), 0);
    chk({tag, "_disp_row"}, 32'(disp_row_b), 0);
    chk({tag, "_rgb"}, 32'({rgb1_b, rgb2_b}), 0);
    chk({tag, "_addr"}, 32'({col_b, row_b}), 0);
    chk({tag, "_frame_start"}, 32'(frame_start_b), 0);
  endtask

  // One bit plane: SHIFT of 2N+2 cycles, one LATCH cycle, BO<<p lit cycles.
  // drop_t: drop enable at that SHIFT cycle; abort_d: assert reset at that lit cycle.
  task automatic walk_plane(input int r, input int p, input int drop_t, input int abort_d);
    int c;
    for (int t = 0; t < 2 * N + 2; t++) begin
      step();
      if (t == drop_t) enable = 1'b0;
      chk("shift_blank", 32'(blank), 1);
      chk("shift_lat", 32'(lat), 0);
      chk("shift_sclk", 32'(sclk), 32'(t >= 3 && (t % 2) == 1));
      chk("frame_start", 32'(frame_start), 32'(t == 0 && r == 0 && p == 0));
      chk("row", 32'(row), r);
      chk("col", 32'(col), (t / 2 < N) ? t / 2 : N - 1);
      chk("shift_disp_row", 32'(disp_row), model_disp_row);
      if (t >= 2) begin
        c = (t - 2) / 2;
        chk("rgb1", 32'(rgb1), 32'(model_bits(mem1[1'(r)][2'(c)], p)));
        chk("rgb2", 32'(rgb2), 32'(model_bits(mem2[1'(r)][2'(c)], p)));
      end
    end
    step();
    model_disp_row = r;
    chk("latch_lat", 32'(lat), 1);
    chk("latch_blank", 32'(blank), 1);
    chk("latch_sclk", 32'(sclk), 0);
    chk("latch_disp_row", 32'(disp_row), r);
    for (int d = 0; d < (BO << p); d++) begin
      step();
      chk("disp_blank", 32'(blank), 0);
      chk("disp_lat", 32'(lat), 0);
      chk("disp_sclk", 32'(sclk), 0);
      chk("disp_row", 32'(disp_row), r);
      chk("disp_frame_start", 32'(frame_start), 0);
      if (d == abort_d) begin
        rst = 1'b0;
        return;
      end
    end
  endtask

  task automatic walk_frame(input int drop_row);
    for (int r = 0; r < ROWS; r++)
      for (int p = 0; p < D; p++)
        walk_plane(r, p, (r == drop_row && p == 0) ? 4 : -1, -1);
  endtask

  task automatic fill_random();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < N; c++) begin
        mem1[r][c] = 6'($urandom);
        mem2[r][c] = 6'($urandom);
      end
  endtask

  initial begin
    int len, w;
    rst = 1'b0; enable = 1'b0; rst_b = 1'b0; en_b = 1'b0;
    px1 = '0; px2 = '0; px1_b = '0; px2_b = '0;
    prev_row = 0; prev_col = 0; model_disp_row = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < N; c++) begin
        mem1[r][c] = '0;
        mem2[r][c] = '0;
      end

    repeat (3) step();
    check_reset_a("rst");
    check_reset_b("rst_b");

    // Release reset with enable high: this cycle is IDLE, the next is SHIFT t=0.
    fill_random();
    enable = 1'b1;
    rst = 1'b1;
    walk_frame(-1);
    fill_random();
    walk_frame(-1);

    // Uniform pixel R=10 G=01 B=11 on both halves.
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < N; c++) begin
        mem1[r][c] = 6'b10_01_11;
        mem2[r][c] = 6'b10_01_11;
      end
    walk_frame(-1);

    // Column index as the upper pixel shows the shift order.
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < N; c++) begin
        mem1[r][c] = 6'(c) | 6'(c << 4);
        mem2[r][c] = 6'($urandom);
      end
    walk_frame(-1);

    // enable drops mid-SHIFT of row 1: row 1 finishes every plane, then IDLE.
    fill_random();
    walk_frame(1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_blank", 32'(blank), 1);
      chk("idle_lat", 32'(lat), 0);
      chk("idle_sclk", 32'(sclk), 0);
      chk("idle_frame_start", 32'(frame_start), 0);
      chk("idle_row", 32'(row), 0);
    end
    enable = 1'b1;
    walk_frame(-1);

    // Reset while lit: blank must rise on the very next cycle.
    walk_plane(0, 0, -1, -1);
    walk_plane(0, 1, -1, 2);
    step();
    check_reset_a("rst_lit");
    model_disp_row = 0;

    // Deep colour, BASE_ON=1: lit periods 1,2,...,128 per row.
    enable = 1'b0;
    en_b = 1'b1;
    rst_b = 1'b1;
    for (int rr = 0; rr < ROWS; rr++) begin
      for (int p = 0; p < DB; p++) begin
        w = 0;
        while (blank_b !== 1'b0 && w < 400) begin
          step();
          w++;
        end
        chk("b_lit_start", 32'(blank_b), 0);
        chk("b_disp_row", 32'(disp_row_b), rr);
        len = 0;
        while (blank_b === 1'b0 && len < 300) begin
          len++;
          if (rr == 1 && p == DB - 1 && len == 60) break;
          step();
        end
        if (rr == 1 && p == DB - 1) begin
          rst_b = 1'b0;
          step();
          check_reset_b("b_rst_lit");
        end else begin
          chk("b_on_time", len, 1 << p);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
